// File: rtl/floor_request_scheduler.sv
// SCAN floor-request scheduler: synchronizes and debounces call buttons, tracks pending calls and drives the target floor.
// Optional define CALL_CANCEL_EN: re-pressing an already pending floor cancels that call.
module floor_request_scheduler #(
  parameter int unsigned NUM_FLOORS      = 9,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_n_i,
  input  logic [3:0]            current_floor_i,
  input  logic                  elev_idle_i,
  output logic [3:0]            requested_floor_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  dir_up_o,
  output logic                  arrive_o
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_UP    = 2'd1;
  localparam logic [1:0] S_DOWN  = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  logic [NUM_FLOORS-1:0] sync1_q, sync2_q, level_q, level_d, press_c;
  logic [DB_W-1:0]       db_cnt_q [NUM_FLOORS];
  logic [DB_W-1:0]       db_cnt_d [NUM_FLOORS];
  logic [1:0]            state_q, state_d;
  logic [3:0]            req_q, req_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic                  dir_q, dir_d, arrive_q, arrive_d;
  logic [DW_W-1:0]       dwell_q, dwell_d;

  logic                  cur_valid, cur_pend, any_above, any_below;
  logic [NUM_FLOORS-1:0] cur_onehot, ignore_c, eff_press_c;
  logic [3:0]            lo_above, hi_below;

  // Debounce: level follows the synchronized button after DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    level_d = level_q;
    press_c = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = sync2_q[i];
          press_c[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Pending calls relative to the reported floor.
  always_comb begin
    cur_valid  = ({1'b0, current_floor_i} < 5'(NUM_FLOORS));
    cur_onehot = '0;
    cur_pend   = 1'b0;
    any_above  = 1'b0;
    any_below  = 1'b0;
    lo_above   = 4'd0;
    hi_below   = 4'd0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (4'(i) == current_floor_i) begin
        cur_onehot[i] = 1'b1;
        cur_pend      = pend_q[i];
      end
      if (pend_q[i] && (4'(i) > current_floor_i)) begin
        any_above = 1'b1;
        lo_above  = 4'(i);
      end
    end
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pend_q[i] && (4'(i) < current_floor_i)) begin
        any_below = 1'b1;
        hi_below  = 4'(i);
      end
    end
  end

  // Next state, target and pending update.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    dir_d       = dir_q;
    dwell_d     = dwell_q;
    arrive_d    = 1'b0;
    ignore_c    = '0;
    eff_press_c = '0;
    pend_d      = pend_q;

    if (!cur_valid) begin
      state_d = S_IDLE;
      req_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_d = current_floor_i;
          if (cur_pend) begin
            state_d = S_DWELL;
          end else if (any_above) begin
            state_d = S_UP;
            req_d   = lo_above;
          end else if (any_below) begin
            state_d = S_DOWN;
            req_d   = hi_below;
          end
        end
        S_UP, S_DOWN: begin
          if ((current_floor_i == req_q) && cur_pend) begin
            if (elev_idle_i) begin
              state_d = S_DWELL;
              req_d   = current_floor_i;
            end
          end else if ((state_q == S_UP) ? any_above : !any_below && any_above) begin
            state_d = S_UP;
            req_d   = lo_above;
          end else if (any_below) begin
            state_d = S_DOWN;
            req_d   = hi_below;
          end else begin
            state_d = S_IDLE;
            req_d   = current_floor_i;
          end
        end
        default: begin
          req_d = current_floor_i;
          if (dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
            if (any_above && (dir_q || !any_below)) begin
              state_d = S_UP;
              req_d   = lo_above;
            end else if (any_below) begin
              state_d = S_DOWN;
              req_d   = hi_below;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      endcase
    end

    if (state_d == S_UP) begin
      dir_d = 1'b1;
    end else if (state_d == S_DOWN) begin
      dir_d = 1'b0;
    end

    // Door is open at the served floor, so its button is ignored there.
    if ((state_q == S_DWELL) && cur_valid) begin
      ignore_c = cur_onehot;
    end
    eff_press_c = press_c & ~ignore_c;
`ifdef CALL_CANCEL_EN
    pend_d = pend_q ^ eff_press_c;
`else
    pend_d = pend_q | eff_press_c;
`endif
    if ((state_d == S_DWELL) && (state_q != S_DWELL)) begin
      arrive_d = 1'b1;
      dwell_d  = '0;
      pend_d   = pend_d & ~cur_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q  <= S_IDLE;
      req_q    <= 4'd0;
      pend_q   <= '0;
      dir_q    <= 1'b1;
      arrive_q <= 1'b0;
      dwell_q  <= '0;
    end else begin
      sync1_q  <= ~call_n_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q  <= state_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      arrive_q <= arrive_d;
      dwell_q  <= dwell_d;
    end
  end

  assign requested_floor_o = req_q;
  assign pending_o         = pend_q;
  assign dir_up_o          = dir_q;
  assign arrive_o          = arrive_q;

endmodule
